// File: rtl/timeout_us_to_mclks_encode.sv
// Converts a microsecond timeout into MCLKs via two sequential restoring
// dividers, then packs the result into the {ms, ls} register encoding.
`timescale 1ns/1ps

module timeout_us_to_mclks_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] timeout_period_us,
  input  logic [7:0]  vcsel_period_pclks,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] timeout_period_mclks,
  output logic [15:0] timeout_encoded
);

  typedef enum logic [2:0] {
    IDLE,
    MACRO_DIV,
    MCLK_DIV,
    ENCODE,
    DONE
  } state_e;

  localparam logic [31:0] MACRO_SCALE   = 32'd3813120; // 2304 * 1655
  localparam logic [31:0] MACRO_ROUND   = 32'd500;
  localparam logic [31:0] MACRO_DIVISOR = 32'd1000;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] us_q, us_d;
  logic [41:0] num_q, num_d;
  logic [31:0] rem_q, rem_d;
  logic [41:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [31:0] mclks_q, mclks_d;
  logic [31:0] ls_q, ls_d;
  logic [7:0]  ms_q, ms_d;
  logic [15:0] enc_q, enc_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [31:0] out_m_q, out_m_d;
  logic [15:0] out_e_q, out_e_d;

  // One restoring-division step shared by both divide phases; the numerator
  // is kept MSB-aligned at bit 41 so both phases shift from the same place.
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_next;
  logic [41:0] quo_next;
  logic [41:0] num_shift;
  logic [31:0] macro_num;
  logic [31:0] macro_ns;
  logic [41:0] us_x1000;
  logic [41:0] mclk_num;
  logic [31:0] mclks_next;

  always_comb begin
    trial      = {rem_q, num_q[41]};
    ge         = (trial >= {1'b0, div_q});
    rem_next   = ge ? (trial[31:0] - div_q) : trial[31:0];
    quo_next   = {quo_q[40:0], ge};
    num_shift  = {num_q[40:0], 1'b0};
    macro_num  = ({24'd0, vcsel_period_pclks} * MACRO_SCALE) + MACRO_ROUND;
    macro_ns   = quo_next[31:0];
    us_x1000   = {10'd0, us_q} * 42'd1000;
    mclk_num   = us_x1000 + {11'd0, macro_ns[31:1]};
    mclks_next = quo_next[31:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    us_d    = us_q;
    num_d   = num_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    mclks_d = mclks_q;
    ls_d    = ls_q;
    ms_d    = ms_q;
    enc_d   = enc_q;
    err_d   = err_q;
    done_d  = 1'b0;
    error_d = error_q;
    out_m_d = out_m_q;
    out_e_d = out_e_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          us_d    = timeout_period_us;
          num_d   = {macro_num, 10'd0};
          rem_d   = '0;
          quo_d   = '0;
          div_d   = MACRO_DIVISOR;
          cnt_d   = '0;
          state_d = MACRO_DIV;
        end
      end
      MACRO_DIV: begin
        num_d = num_shift;
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d = '0;
          if (macro_ns == '0) begin
            err_d   = 1'b1;
            mclks_d = '0;
            enc_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            num_d   = mclk_num;
            rem_d   = '0;
            quo_d   = '0;
            div_d   = macro_ns;
            state_d = MCLK_DIV;
          end
        end
      end
      MCLK_DIV: begin
        num_d = num_shift;
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd41) begin
          cnt_d   = '0;
          mclks_d = mclks_next;
          // Zero maps to ls=0/ms=0 so the encoder needs no shifts.
          ls_d    = (mclks_next == '0) ? '0 : (mclks_next - 32'd1);
          ms_d    = '0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (ls_q > 32'd255) begin
          ls_d = {1'b0, ls_q[31:1]};
          ms_d = ms_q + 8'd1;
        end else begin
          enc_d   = {ms_q, ls_q[7:0]};
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        error_d = err_q;
        out_m_d = mclks_q;
        out_e_d = enc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      us_q    <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      mclks_q <= '0;
      ls_q    <= '0;
      ms_q    <= '0;
      enc_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      out_m_q <= '0;
      out_e_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      us_q    <= us_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      mclks_q <= mclks_d;
      ls_q    <= ls_d;
      ms_q    <= ms_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      error_q <= error_d;
      out_m_q <= out_m_d;
      out_e_q <= out_e_d;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;
  assign error                = error_q;
  assign timeout_period_mclks = out_m_q;
  assign timeout_encoded      = out_e_q;

endmodule

// File: tb/tb_timeout_us_to_mclks_encode.sv
// Directed bench for timeout_us_to_mclks_encode: hand-computed vectors,
// latency counted in clock edges from the accepting edge E0.
`timescale 1ns/1ps

module tb_timeout_us_to_mclks_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] us = '0;
  logic [7:0]  vcsel = '0;
  logic        busy, done, error;
  logic [31:0] timeout_period_mclks;
  logic [15:0] timeout_encoded;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] prev_m = '0;
  logic [15:0] prev_e = '0;

  always #5 clk = ~clk;

  timeout_us_to_mclks_encode dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .timeout_period_us    (us),
    .vcsel_period_pclks   (vcsel),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .timeout_period_mclks (timeout_period_mclks),
    .timeout_encoded      (timeout_encoded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; mode 1: extra start and input changes while busy;
  // mode 2: start held high during the DONE cycle only.
  task automatic run(input string tag, input logic [7:0] v, input logic [31:0] u,
                     input logic [31:0] exp_m, input logic [15:0] exp_e,
                     input logic exp_err, input int exp_lat, input int mode);
    int   edges;
    logic busy_ok;
    @(negedge clk);
    vcsel = v;
    us    = u;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_hold_m"}, timeout_period_mclks, prev_m);
    chk({tag, "_hold_e"}, {16'd0, timeout_encoded}, {16'd0, prev_e});
    edges   = 0;
    busy_ok = 1'b1;
    while (edges < 200) begin
      if (mode == 1 && edges == 1) begin
        vcsel = ~v;
        us    = ~u;
        start = 1'b1;
      end
      if (mode == 1 && edges == 2) start = 1'b0;
      if (mode == 2 && edges == exp_lat - 1) begin
        start = 1'b1;
        vcsel = v + 8'd1;
      end
      @(posedge clk);
      #1;
      edges++;
      if (mode == 2 && edges == exp_lat) start = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({tag, "_mclks"}, timeout_period_mclks, exp_m);
    chk({tag, "_enc"}, {16'd0, timeout_encoded}, {16'd0, exp_e});
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mclks_hold"}, timeout_period_mclks, exp_m);
    prev_m = exp_m;
    prev_e = exp_e;
  endtask

  initial begin
    int   seen_done;
    logic [31:0] rst_m;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mclks", timeout_period_mclks, 32'd0);
    chk("rst_enc", {16'd0, timeout_encoded}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run("nominal", 8'd14, 32'd20000, 32'd375, 16'h01BB, 1'b0, 77, 0);
    run("one_mclk", 8'd14, 32'd27, 32'd1, 16'h0000, 1'b0, 76, 0);
    run("zero_us", 8'd10, 32'd0, 32'd0, 16'h0000, 1'b0, 76, 2);
    run("zero_macro", 8'd0, 32'd1000, 32'd0, 16'h0000, 1'b1, 33, 0);
    run("max_in", 8'd255, 32'hFFFF_FFFF, 32'd4417118, 16'h0F86, 1'b0, 91, 1);

    // Abort with reset at E40, then confirm nothing completes.
    @(negedge clk);
    vcsel = 8'd14;
    us    = 32'd20000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    rst_m = timeout_period_mclks;
    chk("abort_mclks", rst_m, 32'd0);
    chk("abort_enc", {16'd0, timeout_encoded}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    chk("abort_no_done", seen_done, 32'd0);
    prev_m = '0;
    prev_e = '0;
    run("post_reset", 8'd14, 32'd20000, 32'd375, 16'h01BB, 1'b0, 77, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timeout_us_to_mclks_encode.md
TIMEOUT_US_TO_MCLKS_ENCODE -- requirements
Module: timeout_us_to_mclks_encode

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 start  input  1  request pulse; sampled only while busy=0.
REQ-004 timeout_period_us  input  32  requested timeout in microseconds, unsigned.
REQ-005 vcsel_period_pclks  input  8  VCSEL period in PCLKs, unsigned.
REQ-006 busy  output  1  high from the edge that accepts start until the edge that asserts done.
REQ-007 done  output  1  single-cycle completion pulse.
REQ-008 error  output  1  valid with done; 1 = macro period computed as zero.
REQ-009 timeout_period_mclks  output  32  computed timeout in MCLKs.
REQ-010 timeout_encoded  output  16  register-format timeout {ms[7:0], ls[7:0]}.

Function
REQ-011 Edge E0 is the edge at which start=1 and busy=0; both inputs are captured then, and later input changes have no effect.
REQ-012 start while busy=1 is ignored, with no queuing.
REQ-013 The FSM states are IDLE, MACRO_DIV, MCLK_DIV, ENCODE and DONE.
REQ-014 FSM transitions: IDLE->MACRO_DIV at E0; MACRO_DIV->MCLK_DIV after 32 edges; MCLK_DIV->ENCODE after 42 edges; ENCODE->DONE on its final edge; DONE->IDLE after 1 edge.
REQ-015 MACRO_DIV computes macro_ns = floor((2304*vcsel*1655 + 500)/1000) exactly, as a 32-bit unsigned value.
REQ-016 MACRO_DIV uses a restoring divider that resolves one quotient bit per edge (E1..E32); no approximate reciprocal is permitted.
REQ-017 If macro_ns=0 at E32, the FSM goes directly to DONE with error=1, timeout_period_mclks=0 and timeout_encoded=0, so done is high in the cycle after E33.
REQ-018 MCLK_DIV computes mclks = floor((us*1000 + floor(macro_ns/2)) / macro_ns).
REQ-019 MCLK_DIV uses a 42-bit numerator and 32-bit divisor and resolves one quotient bit per edge (E33..E74).
REQ-020 The mclks quotient always fits in 32 bits; no saturation is required.
REQ-021 ENCODE rule for mclks=0: encoded=0x0000.
REQ-022 ENCODE rule for mclks>0: ls=mclks-1, ms=0; while ls>255, shift ls right 1 and increment ms; encoded={ms[7:0], ls[7:0]}.
REQ-023 ENCODE performs one shift per edge (k shifts), then takes one final edge; it occupies E75..E(75+k).
REQ-024 timeout_period_mclks and timeout_encoded are updated at the DONE-entry edge, and done/error are registered at that same edge.
REQ-025 done is high for the cycle after E(76+k) (total latency 76+k edges), and busy falls at that same edge.
REQ-026 Outputs hold their last results until the next DONE; a new start does not clear them.
REQ-027 A start sampled in the DONE cycle is ignored; start is accepted again from the IDLE cycle.

Reset
REQ-028 While reset=0, asynchronously: state=IDLE; busy, done and error = 0; timeout_period_mclks=0; timeout_encoded=0; divider registers cleared.
REQ-029 Reset asserted mid-operation aborts the computation with no done pulse; operation resumes on the first start after reset is released.

Verification
REQ-030 vcsel=14, us=20000 -> macro_ns=53384, mclks=375, encoded=0x01BB, error=0, done high after E77.
REQ-031 vcsel=14, us=27 -> mclks=1, encoded=0x0000; and vcsel=10, us=0 -> mclks=0, encoded=0x0000.
REQ-032 vcsel=255, us=0xFFFFFFFF -> macro_ns=972346, mclks=4417118, encoded=0x0F86, done high after E91.
REQ-033 vcsel=0, us=1000 -> error=1, mclks=0, encoded=0, done high after E33; busy=1 over E1..E33.
REQ-034 Second start during busy, changed inputs after E0, and reset=0 at E40 -> ignored, ignored, and all outputs 0 with no done; a new start after release yields a correct result.
